// File: rtl/rr_sel_arbiter.sv
// Round-robin owner sequencer for one 8-way select resource.
// Grants one requester at a time, holds until release or hold limit, then optional dead gap.
module rr_sel_arbiter #(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N  = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [SW-1:0]   sel_d;
    logic [SW-1:0]   last, last_d;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic [GW-1:0]   gap_cnt, gap_d;
    logic [N-1:0]    gnt_d;
    logic            gnt_valid_d;
    logic            timeout_d;
    logic [SW-1:0]   pick_c;

    // First requester after the previous winner, wrapping 7 -> 0.
    function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] r, input logic [SW-1:0] l);
        logic [SW-1:0] c;
        logic [SW-1:0] w;
        logic          hit;
        w   = l;
        hit = 1'b0;
        for (int i = 1; i <= int'(N); i++) begin
            c = l + SW'(i);
            if (!hit && r[c]) begin
                w   = c;
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb pick_c = rr_pick(req, last);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        sel_d       = sel;
        last_d      = last;
        hold_d      = hold_cnt;
        gap_d       = gap_cnt;
        gnt_d       = gnt;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    sel_d       = pick_c;
                    last_d      = pick_c;
                    hold_d      = '0;
                    gnt_d       = N'(1) << pick_c;
                    gnt_valid_d = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (done || !req[sel]) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gap_d       = '0;
                    state_d     = (GAP_CYCLES != 0) ? GAP : IDLE;
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gap_d       = '0;
                    timeout_d   = 1'b1;
                    state_d     = (GAP_CYCLES != 0) ? GAP : IDLE;
                end else if (hold_cnt != '1) begin
                    hold_d = hold_cnt + HW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + GW'(1);
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; last starts at 7 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            last      <= SW'(N - 1);
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            last      <= last_d;
            hold_cnt  <= hold_d;
            gap_cnt   <= gap_d;
            gnt       <= gnt_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: two instances (hold 16/gap 1 and hold 5/gap 0) against a tenure-level model.
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel_a, sel_b;
    logic [7:0] gnt_a, gnt_b;
    logic       gv_a, gv_b, to_a, to_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    rr_sel_arbiter #(.MAX_HOLD(16), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_a), .gnt(gnt_a), .gnt_valid(gv_a), .timeout(to_a)
    );

    rr_sel_arbiter #(.MAX_HOLD(5), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_b), .gnt(gnt_b), .gnt_valid(gv_b), .timeout(to_b)
    );

    // Reference model: one entry per instance, tracked in tenures and cooldown cycles.
    int mh[2] = '{16, 5};
    int gc[2] = '{1, 0};
    int m_act[2], m_cool[2], m_ten[2], m_own[2], m_last[2], m_to[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_cool[k] = 0; m_ten[k] = 0;
            m_own[k] = 0; m_last[k] = 7; m_to[k] = 0;
        end
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        for (int k = 0; k < 2; k++) begin
            int to_next;
            int w;
            to_next = 0;
            w = -1;
            if (m_act[k] != 0) begin
                if (d || !r[m_own[k]]) begin
                    m_act[k] = 0; m_cool[k] = gc[k];
                end else if (mh[k] != 0 && m_ten[k] + 1 == mh[k]) begin
                    m_act[k] = 0; m_cool[k] = gc[k]; to_next = 1;
                end else begin
                    m_ten[k]++;
                end
            end else if (m_cool[k] > 0) begin
                m_cool[k]--;
            end else if (r != 8'h00) begin
                for (int off = 1; off <= 8; off++)
                    if (w < 0 && r[(m_last[k] + off) % 8]) w = (m_last[k] + off) % 8;
                m_own[k] = w; m_last[k] = w; m_act[k] = 1; m_ten[k] = 0;
            end
            m_to[k] = to_next;
        end
    endtask

    function automatic logic [12:0] exp_vec(input int k);
        logic [7:0] g;
        g = (m_act[k] != 0) ? (8'h01 << m_own[k]) : 8'h00;
        return {3'(m_own[k]), g, (m_act[k] != 0), (m_to[k] != 0)};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle 1 ns after.
    task automatic tick(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input logic [7:0] r, input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            tick(r, 1'b0);
            if (gv_a) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sel_a, gnt_a, gv_a, to_a} !== 13'h0) begin
            failures++; $display("FAIL reset_a got=%h exp=%h", {sel_a, gnt_a, gv_a, to_a}, 13'h0);
        end
        checks++;
        if ({sel_b, gnt_b, gv_b, to_b} !== 13'h0) begin
            failures++; $display("FAIL reset_b got=%h exp=%h", {sel_b, gnt_b, gv_b, to_b}, 13'h0);
        end
        rst_n = 1'b1;
        tick(8'hFF, 1'b0);
        checks++;
        if (sel_a !== 3'd0 || gnt_a !== 8'h01 || gv_a !== 1'b1) begin
            failures++; $display("FAIL first_grant got sel=%0d gnt=%h gv=%b exp sel=0 gnt=01 gv=1", sel_a, gnt_a, gv_a);
        end
        checks++;
        if (sel_b !== 3'd0 || gnt_b !== 8'h01 || gv_b !== 1'b1) begin
            failures++; $display("FAIL first_grant_b got sel=%0d gnt=%h gv=%b exp sel=0 gnt=01 gv=1", sel_b, gnt_b, gv_b);
        end
    endtask

    task automatic test_round_robin();
        int  seq[$];
        int  dead;
        bit  prev;
        do_reset();
        dead = 0;
        prev = 1'b0;
        for (int i = 0; i < 60 && seq.size() < 9; i++) begin
            tick(8'hFF, m_act[0] != 0);
            checks++;
            if ({sel_a, gnt_a, gv_a, to_a} !== exp_vec(0)) begin
                failures++; $display("FAIL rr_model_a cyc=%0d got=%h exp=%h", cyc, {sel_a, gnt_a, gv_a, to_a}, exp_vec(0));
            end
            if (gv_a && !prev) begin
                seq.push_back(int'(sel_a));
                // Between tenures: GAP_CYCLES gap cycles plus the IDLE arbitration cycle.
                if (seq.size() > 1) begin
                    checks++;
                    if (dead != gc[0] + 1) begin
                        failures++; $display("FAIL rr_dead_cycles got=%0d exp=%0d", dead, gc[0] + 1);
                    end
                end
                dead = 0;
            end
            if (!gv_a) dead++;
            prev = gv_a;
        end
        checks++;
        if (seq.size() != 9) begin
            failures++; $display("FAIL rr_grant_count got=%0d exp=9", seq.size());
        end
        for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (seq[i] != i % 8) begin
                failures++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, seq[i], i % 8);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int g = 0; g < 4; g++) begin
            tick(8'hFF, 1'b0);
            checks++;
            if (gv_b !== 1'b1 || sel_b !== 3'(g) || gnt_b !== (8'h01 << g)) begin
                failures++; $display("FAIL b2b_grant g=%0d got gv=%b sel=%0d gnt=%h exp sel=%0d", g, gv_b, sel_b, gnt_b, g);
            end
            tick(8'hFF, 1'b1);
            checks++;
            if (gv_b !== 1'b0 || gnt_b !== 8'h00) begin
                failures++; $display("FAIL b2b_release g=%0d got gv=%b gnt=%h exp gv=0 gnt=00", g, gv_b, gnt_b);
            end
        end
    endtask

    task automatic test_wrap();
        bit got;
        do_reset();
        wait_grant(8'h10, 6, got);
        checks++;
        if (!got || sel_a !== 3'd4) begin
            failures++; $display("FAIL wrap_setup got=%b sel=%0d exp sel=4", got, sel_a);
        end
        tick(8'h90, 1'b1);
        wait_grant(8'h90, 6, got);
        checks++;
        if (!got || sel_a !== 3'd7 || gnt_a !== 8'h80) begin
            failures++; $display("FAIL wrap_to_7 got=%b sel=%0d gnt=%h exp sel=7 gnt=80", got, sel_a, gnt_a);
        end
        tick(8'h90, 1'b1);
        wait_grant(8'h90, 6, got);
        checks++;
        if (!got || sel_a !== 3'd4 || gnt_a !== 8'h10) begin
            failures++; $display("FAIL wrap_to_4 got=%b sel=%0d gnt=%h exp sel=4 gnt=10", got, sel_a, gnt_a);
        end
    endtask

    task automatic test_timeout();
        bit got;
        int n;
        do_reset();
        wait_grant(8'h03, 6, got);
        checks++;
        if (!got || sel_a !== 3'd0) begin
            failures++; $display("FAIL to_first got=%b sel=%0d exp sel=0", got, sel_a);
        end
        n = 1;
        for (int i = 0; i < 40 && gv_a; i++) begin
            tick(8'h03, 1'b0);
            if (gv_a) n++;
        end
        checks++;
        if (n != 16) begin
            failures++; $display("FAIL to_hold_len got=%0d exp=16", n);
        end
        checks++;
        if (to_a !== 1'b1 || gv_a !== 1'b0) begin
            failures++; $display("FAIL to_pulse got to=%b gv=%b exp to=1 gv=0", to_a, gv_a);
        end
        tick(8'h03, 1'b0);
        checks++;
        if (to_a !== 1'b0) begin
            failures++; $display("FAIL to_pulse_width got=%b exp=0", to_a);
        end
        wait_grant(8'h03, 6, got);
        checks++;
        if (!got || sel_a !== 3'd1 || gnt_a !== 8'h02) begin
            failures++; $display("FAIL to_next_owner got=%b sel=%0d gnt=%h exp sel=1 gnt=02", got, sel_a, gnt_a);
        end
    endtask

    task automatic test_withdraw();
        bit got;
        do_reset();
        wait_grant(8'h0C, 6, got);
        checks++;
        if (!got || sel_a !== 3'd2) begin
            failures++; $display("FAIL wd_grant got=%b sel=%0d exp sel=2", got, sel_a);
        end
        tick(8'h0C, 1'b0);
        tick(8'h0C, 1'b0);
        tick(8'h08, 1'b0);
        checks++;
        if (gv_a !== 1'b0 || gnt_a !== 8'h00 || to_a !== 1'b0) begin
            failures++; $display("FAIL wd_release got gv=%b gnt=%h to=%b exp gv=0 gnt=00 to=0", gv_a, gnt_a, to_a);
        end
        wait_grant(8'h08, 6, got);
        checks++;
        if (!got || sel_a !== 3'd3) begin
            failures++; $display("FAIL coin_grant got=%b sel=%0d exp sel=3", got, sel_a);
        end
        for (int i = 0; i < 14; i++) tick(8'h08, 1'b0);
        checks++;
        if (gv_a !== 1'b1) begin
            failures++; $display("FAIL coin_still_held got=%b exp=1", gv_a);
        end
        tick(8'h08, 1'b1);
        checks++;
        if (gv_a !== 1'b0 || to_a !== 1'b0) begin
            failures++; $display("FAIL coin_no_timeout got gv=%b to=%b exp gv=0 to=0", gv_a, to_a);
        end
        tick(8'h08, 1'b0);
        checks++;
        if (to_a !== 1'b0) begin
            failures++; $display("FAIL coin_late_timeout got=%b exp=0", to_a);
        end
    endtask

    task automatic test_reset_busy();
        bit got;
        do_reset();
        wait_grant(8'h08, 6, got);
        tick(8'h08, 1'b0);
        checks++;
        if (!got || gv_a !== 1'b1 || sel_a !== 3'd3) begin
            failures++; $display("FAIL rb_setup got gv=%b sel=%0d exp gv=1 sel=3", gv_a, sel_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gv_a !== 1'b0 || gnt_a !== 8'h00 || gv_b !== 1'b0 || gnt_b !== 8'h00) begin
            failures++; $display("FAIL rb_async got gv_a=%b gnt_a=%h gv_b=%b gnt_b=%h exp all 0", gv_a, gnt_a, gv_b, gnt_b);
        end
        model_reset();
        req  = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_grant(8'hFF, 6, got);
        checks++;
        if (!got || sel_a !== 3'd0 || gnt_a !== 8'h01) begin
            failures++; $display("FAIL rb_restart got=%b sel=%0d gnt=%h exp sel=0 gnt=01", got, sel_a, gnt_a);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       d;
        do_reset();
        r = 8'($urandom);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            d = ($urandom_range(0, 4) == 0);
            tick(r, d);
            checks++;
            if ({sel_a, gnt_a, gv_a, to_a} !== exp_vec(0)) begin
                failures++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", cyc, {sel_a, gnt_a, gv_a, to_a}, exp_vec(0));
            end
            checks++;
            if ({sel_b, gnt_b, gv_b, to_b} !== exp_vec(1)) begin
                failures++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc, {sel_b, gnt_b, gv_b, to_b}, exp_vec(1));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_withdraw();
        test_reset_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
